// File: rtl/minilcd_pkg.sv
// minilcd_pkg: panel constants, channel tags, fill FSM states and RGB565 byte helper
package minilcd_pkg;
  localparam int LCD_W = 128;
  localparam int LCD_H = 128;
  localparam logic [1:0] CH_R = 2'b00;
  localparam logic [1:0] CH_G = 2'b01;
  localparam logic [1:0] CH_B = 2'b10;
  typedef enum logic [2:0] {IDLE, WR_R, WR_G, WR_B, FIN} state_t;
  function automatic logic [7:0] vram_byte(input logic [15:0] color, input logic [1:0] ch);
    return ch == CH_R ? {CH_R, 1'b0, color[15:11]} :
           ch == CH_G ? {CH_G, color[10:5]} : {CH_B, 1'b0, color[4:0]};
  endfunction
endpackage

// File: rtl/minilcd_rect_clip.sv
// minilcd_rect_clip: clips a rectangle to the panel and yields its last column/row
module minilcd_rect_clip
  import minilcd_pkg::*;
#(
  parameter int XBITS = 7,
  parameter int YBITS = 7
) (
  input  logic [XBITS-1:0] x,
  input  logic [YBITS-1:0] y,
  input  logic [7:0]       w,
  input  logic [7:0]       h,
  output logic             empty,
  output logic [XBITS-1:0] end_col,
  output logic [YBITS-1:0] end_row
);
  logic [7:0] x_room, y_room, wc, hc;
  assign x_room  = 8'(LCD_W) - 8'(x);
  assign y_room  = 8'(LCD_H) - 8'(y);
  assign wc      = w < x_room ? w : x_room;
  assign hc      = h < y_room ? h : y_room;
  assign empty   = wc == 8'd0 || hc == 8'd0;
  assign end_col = XBITS'(8'(x) + wc - 8'd1);
  assign end_row = YBITS'(8'(y) + hc - 8'd1);
endmodule

// File: rtl/minilcd_rectfill.sv
// minilcd_rectfill: rectangle fill engine writing R/G/B tagged bytes into MiniLCD VRAM
module minilcd_rectfill
  import minilcd_pkg::*;
#(
  parameter int XBITS = 7,
  parameter int YBITS = 7
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   CMD_VALID,
  output logic                   CMD_READY,
  input  logic [XBITS-1:0]       CMD_X,
  input  logic [YBITS-1:0]       CMD_Y,
  input  logic [7:0]             CMD_W,
  input  logic [7:0]             CMD_H,
  input  logic [15:0]            CMD_COLOR,
  output logic                   BUSY,
  output logic                   DONE,
  output logic [YBITS+XBITS-1:0] VRAM_ADDR,
  output logic [7:0]             VRAM_DATA,
  output logic                   VRAM_WE
);
  state_t state, state_n;
  logic [XBITS-1:0] x0, x0_n, col, col_n, ec, ec_n, clip_ec;
  logic [YBITS-1:0] row, row_n, er, er_n, clip_er;
  logic [15:0] color, color_n;
  logic clip_empty, accept, wr_n;
  logic [1:0] ch_n;
  minilcd_rect_clip #(.XBITS(XBITS), .YBITS(YBITS)) u_clip (
    .x(CMD_X), .y(CMD_Y), .w(CMD_W), .h(CMD_H),
    .empty(clip_empty), .end_col(clip_ec), .end_row(clip_er)
  );
  // Next state and scan position; command fields are latched only on the accepting cycle
  always_comb begin
    accept  = state == IDLE && CMD_VALID;
    x0_n    = accept ? CMD_X : x0;
    ec_n    = accept ? clip_ec : ec;
    er_n    = accept ? clip_er : er;
    color_n = accept ? CMD_COLOR : color;
    state_n = state;
    col_n   = col;
    row_n   = row;
    case (state)
      IDLE: if (accept) begin
        state_n = clip_empty ? FIN : WR_R;
        col_n   = CMD_X;
        row_n   = CMD_Y;
      end
      WR_R: state_n = WR_G;
      WR_G: state_n = WR_B;
      WR_B: if (col != ec) begin
        col_n   = col + 1'b1;
        state_n = WR_R;
      end else if (row != er) begin
        col_n   = x0;
        row_n   = row + 1'b1;
        state_n = WR_R;
      end else state_n = FIN;
      default: state_n = IDLE;
    endcase
    wr_n = state_n inside {WR_R, WR_G, WR_B};
    ch_n = state_n == WR_R ? CH_R : state_n == WR_G ? CH_G : CH_B;
  end
  // State and captured command registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      x0    <= '0;
      col   <= '0;
      row   <= '0;
      ec    <= '0;
      er    <= '0;
      color <= '0;
    end else begin
      state <= state_n;
      x0    <= x0_n;
      col   <= col_n;
      row   <= row_n;
      ec    <= ec_n;
      er    <= er_n;
      color <= color_n;
    end
  end
  // Outputs are registered from the next state so each write lands in the cycle its state is entered
  always_ff @(posedge CLK) begin
    if (RST) begin
      CMD_READY <= 1'b1;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      VRAM_WE   <= 1'b0;
      VRAM_ADDR <= '0;
      VRAM_DATA <= '0;
    end else begin
      CMD_READY <= !wr_n;
      BUSY      <= wr_n;
      DONE      <= state_n == FIN;
      VRAM_WE   <= wr_n;
      if (wr_n) begin
        VRAM_ADDR <= {row_n, col_n};
        VRAM_DATA <= vram_byte(color_n, ch_n);
      end
    end
  end
endmodule

// File: tb/tb_minilcd_rectfill.sv
// tb_minilcd_rectfill: random and directed fills checked against a write-list model every cycle
module tb_minilcd_rectfill;
  logic CLK = 0, RST = 1, CMD_VALID = 0;
  logic [6:0] CMD_X = 0, CMD_Y = 0;
  logic [7:0] CMD_W = 0, CMD_H = 0;
  logic [15:0] CMD_COLOR = 0;
  logic CMD_READY, BUSY, DONE, VRAM_WE;
  logic [13:0] VRAM_ADDR;
  logic [7:0] VRAM_DATA;

  minilcd_rectfill dut (
    .CLK(CLK), .RST(RST), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_X(CMD_X), .CMD_Y(CMD_Y), .CMD_W(CMD_W), .CMD_H(CMD_H), .CMD_COLOR(CMD_COLOR),
    .BUSY(BUSY), .DONE(DONE), .VRAM_ADDR(VRAM_ADDR), .VRAM_DATA(VRAM_DATA), .VRAM_WE(VRAM_WE)
  );

  always #5 CLK = ~CLK;

  typedef enum {M_IDLE, M_RUN, M_FIN} mstate_t;
  mstate_t m_state = M_IDLE;
  int vectors = 0, errors = 0, cyc = 0, wr_cnt = 0, acc_cnt = 0;
  logic [21:0] exp_q[$], wr_log[$];
  int done_log[$], hs_log[$];
  logic e_we = 0, e_done = 0, e_ready = 1, e_busy = 0;
  logic [13:0] e_addr = 0;
  logic [7:0] e_data = 0;
  bit armed = 0;
  logic [13:0] a2[4] = '{14'h0000, 14'h0001, 14'h0080, 14'h0081};
  logic [7:0] d2[3] = '{8'h00, 8'h7F, 8'h80};

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", n, act, exp, cyc);
    end
  endtask

  function automatic void build(int x, int y, int w, int h, logic [15:0] c);
    int wc = w < 128 - x ? w : 128 - x;
    int hc = h < 128 - y ? h : 128 - y;
    logic [13:0] a;
    for (int r = 0; r < hc; r++)
      for (int k = 0; k < wc; k++) begin
        a = 14'((y + r) * 128 + x + k);
        exp_q.push_back({a, 3'b000, c[15:11]});
        exp_q.push_back({a, 2'b01, c[10:5]});
        exp_q.push_back({a, 3'b100, c[4:0]});
      end
  endfunction

  initial forever begin
    @(posedge CLK);
    if (RST) begin
      exp_q.delete();
      m_state = M_IDLE;
      e_we = 0;
      e_addr = 0;
      e_data = 0;
      armed = 1;
    end else begin
      case (m_state)
        M_IDLE: if (CMD_VALID) begin
          build(int'(CMD_X), int'(CMD_Y), int'(CMD_W), int'(CMD_H), CMD_COLOR);
          hs_log.push_back(cyc);
          acc_cnt++;
          m_state = exp_q.size() == 0 ? M_FIN : M_RUN;
        end
        M_RUN: if (exp_q.size() == 0) m_state = M_FIN;
        default: m_state = M_IDLE;
      endcase
      e_we = m_state == M_RUN;
      if (e_we) begin
        {e_addr, e_data} = exp_q.pop_front();
        wr_cnt++;
      end
    end
    e_done = m_state == M_FIN;
    e_ready = m_state != M_RUN;
    e_busy = m_state == M_RUN;
    cyc++;
  end

  initial forever begin
    @(negedge CLK);
    if (armed) begin
      chk("we", VRAM_WE, e_we);
      chk("addr", VRAM_ADDR, e_addr);
      chk("data", VRAM_DATA, e_data);
      chk("done", DONE, e_done);
      chk("ready", CMD_READY, e_ready);
      chk("busy", BUSY, e_busy);
      if (VRAM_WE) wr_log.push_back({VRAM_ADDR, VRAM_DATA});
      if (DONE) done_log.push_back(cyc);
    end
  end

  task automatic drive(input int x, input int y, input int w, input int h, input logic [15:0] c);
    CMD_X = 7'(x);
    CMD_Y = 7'(y);
    CMD_W = 8'(w);
    CMD_H = 8'(h);
    CMD_COLOR = c;
    CMD_VALID = 1;
  endtask

  task automatic await_accept();
    int n0 = acc_cnt;
    for (int i = 0; i < 500 && acc_cnt == n0; i++) @(negedge CLK);
    chk("accept", 32'(acc_cnt != n0), 1);
  endtask

  task automatic await_idle();
    for (int i = 0; i < 5000 && m_state != M_IDLE; i++) begin
      @(negedge CLK);
      if (!CMD_VALID) begin
        CMD_X = 7'($urandom);
        CMD_Y = 7'($urandom);
        CMD_W = 8'($urandom);
        CMD_H = 8'($urandom);
        CMD_COLOR = 16'($urandom);
      end
    end
    chk("idle", 32'(m_state == M_IDLE), 1);
    @(negedge CLK);
    #1;
  endtask

  task automatic fill(input int x, input int y, input int w, input int h, input logic [15:0] c);
    @(negedge CLK);
    drive(x, y, w, h, c);
    await_accept();
    CMD_VALID = 0;
    await_idle();
  endtask

  task automatic clear_logs();
    wr_log.delete();
    done_log.delete();
    hs_log.delete();
  endtask

  initial begin
    int x, y, w, h, w0;
    repeat (3) @(negedge CLK);
    RST = 0;
    @(negedge CLK);
    #1;
    chk("rst_ready", CMD_READY, 1);
    chk("rst_busy", BUSY, 0);
    chk("rst_we", VRAM_WE, 0);
    chk("rst_addr", VRAM_ADDR, 0);

    clear_logs();
    fill(5, 2, 1, 1, 16'hF800);
    chk("px_count", wr_log.size(), 3);
    chk("px_r", wr_log[0], {14'h0105, 8'h1F});
    chk("px_g", wr_log[1], {14'h0105, 8'h40});
    chk("px_b", wr_log[2], {14'h0105, 8'h80});
    chk("px_done", done_log[0] - hs_log[0], 4);

    clear_logs();
    fill(0, 0, 2, 2, 16'h07E0);
    chk("r2_count", wr_log.size(), 12);
    for (int p = 0; p < 4; p++)
      for (int k = 0; k < 3; k++) chk("r2_write", wr_log[p*3+k], {a2[p], d2[k]});
    chk("r2_done", done_log[0] - hs_log[0], 13);

    clear_logs();
    fill(126, 127, 10, 10, 16'h001F);
    chk("clip_count", wr_log.size(), 6);
    chk("clip_a0", wr_log[0], {14'h3FFE, 8'h00});
    chk("clip_a1", wr_log[1], {14'h3FFE, 8'h40});
    chk("clip_a2", wr_log[2], {14'h3FFE, 8'h9F});
    chk("clip_b2", wr_log[5], {14'h3FFF, 8'h9F});
    chk("clip_done", done_log[0] - hs_log[0], 7);

    clear_logs();
    fill(10, 10, 0, 5, 16'hFFFF);
    chk("empty_count", wr_log.size(), 0);
    chk("empty_done", done_log[0] - hs_log[0], 1);

    clear_logs();
    @(negedge CLK);
    drive(3, 4, 2, 1, 16'hABCD);
    await_accept();
    drive(100, 50, 1, 1, 16'h1234);
    await_accept();
    CMD_VALID = 0;
    await_idle();
    chk("b2b_accept", hs_log[1], done_log[0] + 1);
    chk("b2b_count", wr_log.size(), 9);
    chk("b2b_a_last", wr_log[5][21:8], 14'h0204);
    chk("b2b_r", wr_log[6], {14'h1964, 8'h02});
    chk("b2b_g", wr_log[7], {14'h1964, 8'h51});
    chk("b2b_b", wr_log[8], {14'h1964, 8'h94});

    clear_logs();
    w0 = wr_cnt;
    @(negedge CLK);
    drive(10, 10, 4, 4, 16'h5A5A);
    await_accept();
    CMD_VALID = 0;
    for (int i = 0; i < 100 && wr_cnt - w0 < 7; i++) @(negedge CLK);
    RST = 1;
    @(negedge CLK);
    RST = 0;
    repeat (3) @(negedge CLK);
    #1;
    chk("rstmid_count", wr_log.size(), 7);
    chk("rstmid_done", done_log.size(), 0);
    chk("rstmid_ready", CMD_READY, 1);
    chk("rstmid_busy", BUSY, 0);
    chk("rstmid_we", VRAM_WE, 0);

    for (int n = 0; n < 30; n++) begin
      x = $urandom_range(0, 127);
      y = $urandom_range(0, 127);
      w = $urandom_range(0, 6);
      h = $urandom_range(0, 6);
      if ($urandom_range(0, 2) == 0) begin
        x = $urandom_range(118, 127);
        w = $urandom_range(0, 255);
      end
      if ($urandom_range(0, 2) == 0) begin
        y = $urandom_range(118, 127);
        h = $urandom_range(0, 255);
      end
      fill(x, y, w, h, 16'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
